// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell; addition twin of the 1-bit subtractor cell.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial handshake adder, LSB first, result {carry, sum} in S.
// Optional subtract mode via macro SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder4
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   S
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] yb_q, yb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH:0]   s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sub_q, sub_d;
  logic             sub_in;
  logic             fa_s, fa_c;
  logic             carry_out;
  logic [WIDTH-1:0] sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in    = sub;
  // Subtraction runs as X + ~Y + 1; the reported borrow is the inverted carry.
  assign carry_out = sub_q ? ~fa_c : fa_c;
`else
  assign sub_in    = 1'b0;
  assign carry_out = fa_c;
`endif

  full_adder_1bit u_fa (
    .a   (xa_q[0]),
    .b   (yb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    yb_d    = yb_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          xa_d    = X;
          yb_d    = sub_in ? ~Y : Y;
          sub_d   = sub_in;
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        xa_d    = xa_q >> 1;
        yb_d    = yb_q >> 1;
        sum_d   = sum_shift;
        carry_d = fa_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          s_d     = {carry_out, sum_shift};
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xa_q    <= '0;
      yb_q    <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;

endmodule

// File: tb/tb_serial_adder4.sv
// Directed self-checking bench for serial_adder4 (WIDTH=4).
module tb_serial_adder4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] X, Y;
  logic       busy, done;
  logic [4:0] S;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_adder4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .X    (X),
    .Y    (Y),
    .busy (busy),
    .done (done),
    .S    (S)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete operation: accept, 4 busy cycles, one-cycle done, S held.
  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [4:0] exp);
    X = x; Y = y; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq({tag, " busy"}, busy, 1);
      check_eq({tag, " done_early"}, done, 0);
      step();
    end
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " busy_off"}, busy, 0);
    check_eq({tag, " S"}, S, exp);
    step();
    check_eq({tag, " done_pulse"}, done, 0);
    check_eq({tag, " S_hold"}, S, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #2;
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst S", S, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    run_op("9+5", 4'd9, 4'd5, 5'b01110);
    run_op("15+15", 4'd15, 4'd15, 5'b11110);
    run_op("0+0", 4'd0, 4'd0, 5'b00000);

    // start re-pulsed and operands changed during RUN must be ignored
    X = 4'd6; Y = 4'd3; start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; X = 4'd15; Y = 4'd15;
      step();
      check_eq("ign busy", busy, 1);
    end
    start = 1'b0;
    step();
    check_eq("ign done", done, 1);
    check_eq("ign S", S, 9);
    step();
    check_eq("ign idle", busy, 0);

    // start held high: results every 5 cycles
    X = 4'd1; Y = 4'd2; start = 1'b1;
    step();
    for (int k = 1; k <= 14; k++) begin
      step();
      check_eq("b2b done", done, ((k % 5) == 4) ? 1 : 0);
      check_eq("b2b busy", busy, ((k % 5) == 4) ? 0 : 1);
      if ((k % 5) == 4) check_eq("b2b S", S, 3);
    end
    start = 1'b0;
    step();
    check_eq("b2b idle busy", busy, 0);
    check_eq("b2b idle done", done, 0);

    // reset during the 2nd RUN cycle
    X = 4'd9; Y = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("abort pre busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort busy", busy, 0);
    check_eq("abort done", done, 0);
    check_eq("abort S", S, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("abort no done", done, 0);
      check_eq("abort no busy", busy, 0);
    end

    run_op("post 15+15", 4'd15, 4'd15, 5'd30);
    run_op("post 0+0", 4'd0, 4'd0, 5'd0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("3-5", 4'd3, 4'd5, 5'b11110);
    run_op("7-2", 4'd7, 4'd2, 5'b00101);
    sub = 1'b0;
    run_op("7+2", 4'd7, 4'd2, 5'b01001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
